// File: rtl/velocity_cell_reader_if.sv
// Bundles the velocity RAM read port and the outbound velocity stream.
// The master (reader) drives the RAM controls and the stream, and the slave side supplies mem_q and out_ready.
interface velocity_cell_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output mem_address, mem_rden, mem_wren, mem_data,
        input  mem_q,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_rden, mem_wren, mem_data,
        output mem_q,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/velocity_cell_reader.sv
// Reads a cell's particle count from word 0, then streams velocity words 1..count
// through a 3-entry credit-limited FIFO to a valid/ready consumer.
module velocity_cell_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    velocity_cell_reader_if.master bus
);
    localparam int DEPTH = 3;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_CNT   = 3'd1;
    localparam logic [2:0] S_WAIT_CNT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] pcount_q, pcount_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_idx_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_idx_d  [DEPTH];

    logic                  cnt_rd, issue, push, pop, out_valid_c, out_last_c;
    logic [ADDR_WIDTH-1:0] cnt_raw, mem_addr_c;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        cnt_rd      = (state_q == S_RD_CNT);
        // One read may be in flight; never promise more words than the FIFO can hold.
        issue       = (state_q == S_STREAM) && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        push        = inflight_q;
        out_valid_c = (occ_q != 2'd0);
        pop         = out_valid_c && bus.out_ready;
        out_last_c  = out_valid_c && (fifo_idx_q[rd_ptr_q] == pcount_q);
        cnt_raw     = bus.mem_q[ADDR_WIDTH-1:0];

        if (cnt_rd)
            mem_addr_c = '0;
        else if (issue)
            mem_addr_c = next_addr_q;
        else
            mem_addr_c = mem_addr_q;

        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = err_q;
        pcount_d    = pcount_q;
        next_addr_d = next_addr_q;
        mem_addr_d  = mem_addr_c;
        inflight_d  = issue;
        infl_idx_d  = issue ? next_addr_q : infl_idx_q;

        case (state_q)
            S_IDLE: begin
                // busy_q stays high through the done cycle, which also masks start there.
                if (start && !busy_q) begin
                    state_d = S_RD_CNT;
                    err_d   = 1'b0;
                end
            end
            S_RD_CNT:   state_d = S_WAIT_CNT;
            S_WAIT_CNT: begin
                if (cnt_raw > MAX_COUNT) begin
                    pcount_d = MAX_COUNT;
                    err_d    = 1'b1;
                end else begin
                    pcount_d = cnt_raw;
                end
                if (cnt_raw == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_STREAM;
                    next_addr_d = ADDR_WIDTH'(1);
                end
            end
            S_STREAM: begin
                if (issue) begin
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    if (next_addr_q == pcount_q)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && out_last_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || done_d;

        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.mem_q;
            fifo_idx_d[wr_ptr_q]  = infl_idx_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pcount_q    <= '0;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
            inflight_q  <= 1'b0;
            infl_idx_q  <= '0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pcount_q    <= pcount_d;
            next_addr_q <= next_addr_d;
            mem_addr_q  <= mem_addr_d;
            inflight_q  <= inflight_d;
            infl_idx_q  <= infl_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fifo_data_q[gi] <= '0;
                fifo_idx_q[gi]  <= '0;
            end else begin
                fifo_data_q[gi] <= fifo_data_d[gi];
                fifo_idx_q[gi]  <= fifo_idx_d[gi];
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign count_err       = err_q;
    assign particle_count  = pcount_q;
    assign bus.mem_address = mem_addr_c;
    assign bus.mem_rden    = cnt_rd || issue;
    assign bus.mem_wren    = 1'b0;
    assign bus.mem_data    = '0;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_data    = fifo_data_q[rd_ptr_q];
    assign bus.out_index   = fifo_idx_q[rd_ptr_q];
    assign bus.out_last    = out_last_c;
endmodule

// File: tb/tb_velocity_cell_reader.sv
// Directed bench for velocity_cell_reader: a behavioural 1-cycle RAM, a negedge monitor
// logging reads/handshakes/done/busy, and hand-derived expectations per pass.
module tb_velocity_cell_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, count_err;
    logic [AW-1:0] particle_count;

    velocity_cell_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .count_err      (count_err),
        .particle_count (particle_count),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:PN-1];
    always @(posedge clk) if (bus.mem_rden) bus.mem_q <= ram[bus.mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            rd_addr[$], rd_cyc[$], hs_idx[$], hs_cyc[$], done_cyc[$], busy_cyc[$];
    logic [DW-1:0] hs_data[$];
    bit            hs_last[$];
    int            stall_err = 0, wren_err = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    always @(negedge clk) begin
        if (bus.mem_wren !== 1'b0 || bus.mem_data !== '0) wren_err++;
        if (rst_n) begin
            if (bus.mem_rden) begin
                rd_addr.push_back(int'(bus.mem_address));
                rd_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_idx.push_back(int'(bus.out_index));
                hs_data.push_back(bus.out_data);
                hs_last.push_back(bus.out_last);
                hs_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cyc.push_back(cyc);
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_index !== prev_idx))
                stall_err++;
        end
        prev_stall = rst_n && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_idx   = bus.out_index;
    end

    int n_checks = 0, n_pass = 0;
    int rd0, hs0, d0, b0, se0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] vel(input int i);
        logic [31:0] k;
        k = 32'(i);
        return {32'hC000_0000 | k, 32'hB000_0000 | k, 32'hA000_0000 | k};
    endfunction

    task automatic load_cell(input int c);
        logic [7:0] cv;
        cv = 8'(c);
        ram[0] = {88'd0, cv};
        for (int i = 1; i < PN; i++) ram[i] = vel(i);
    endtask

    task automatic mark();
        rd0 = rd_addr.size(); hs0 = hs_idx.size(); d0 = done_cyc.size();
        b0 = busy_cyc.size(); se0 = stall_err;
    endtask

    task automatic start_pass(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int mode);
        int step = 0;
        while (done_cyc.size() == d0 && step < budget) begin
            @(posedge clk); #1;
            bus.out_ready = (mode == 0) ? 1'b1 : pat[step % 6];
            step++;
        end
        chk("done_seen", done_cyc.size() - d0, 1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify_stream(input string tag, input int n);
        int bad = 0;
        chk({tag, "_words"}, hs_idx.size() - hs0, n);
        for (int i = 0; i < n && hs0 + i < hs_idx.size(); i++) begin
            if (hs_idx[hs0 + i] != i + 1) bad++;
            if (hs_data[hs0 + i] !== vel(i + 1)) bad++;
            if (hs_last[hs0 + i] != (i == n - 1)) bad++;
        end
        chk({tag, "_seq"}, bad, 0);
        if (n > 0 && hs_idx.size() >= hs0 + n && done_cyc.size() > d0)
            chk({tag, "_done_after_last"}, done_cyc[d0], hs_cyc[hs0 + n - 1] + 1);
        $display("pass %s words=%0d", tag, hs_idx.size() - hs0);
    endtask

    task automatic verify_reads(input string tag, input int n);
        int bad = 0;
        chk({tag, "_reads"}, rd_addr.size() - rd0, n + 1);
        for (int i = 0; i <= n && rd0 + i < rd_addr.size(); i++)
            if (rd_addr[rd0 + i] != i) bad++;
        chk({tag, "_read_addrs"}, bad, 0);
    endtask

    initial begin
        int t0;
        int found;
        bus.out_ready = 1'b1;
        load_cell(3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(count_err), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_rden", int'(bus.mem_rden), 0);
        chk("rst_pcount", int'(particle_count), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // count = 3, ready always high
        mark();
        start_pass(t0);
        wait_done(60, 0);
        verify_reads("c3", 3);
        if (rd_cyc.size() >= rd0 + 4) begin
            chk("c3_cnt_rd_cyc", rd_cyc[rd0] - t0, 1);
            chk("c3_rd1_cyc", rd_cyc[rd0 + 1] - t0, 3);
            chk("c3_rd3_cyc", rd_cyc[rd0 + 3] - t0, 5);
        end
        verify_stream("c3", 3);
        if (hs_cyc.size() >= hs0 + 3) begin
            chk("c3_first_valid", hs_cyc[hs0] - t0, 5);
            chk("c3_b2b", hs_cyc[hs0 + 2] - hs_cyc[hs0], 2);
        end
        if (done_cyc.size() > d0) chk("c3_done_cyc", done_cyc[d0] - t0, 8);
        chk("c3_busy_len", busy_cyc.size() - b0, 8);
        if (busy_cyc.size() > b0) chk("c3_busy_first", busy_cyc[b0] - t0, 1);
        chk("c3_pcount", int'(particle_count), 3);
        chk("c3_err", int'(count_err), 0);

        // count = 0
        load_cell(0);
        mark();
        start_pass(t0);
        wait_done(30, 0);
        verify_reads("c0", 0);
        chk("c0_words", hs_idx.size() - hs0, 0);
        if (done_cyc.size() > d0) chk("c0_done_cyc", done_cyc[d0] - t0, 3);
        chk("c0_busy_len", busy_cyc.size() - b0, 3);
        if (busy_cyc.size() > b0) chk("c0_busy_first", busy_cyc[b0] - t0, 1);

        // count = 5 with ready toggling
        load_cell(5);
        mark();
        start_pass(t0);
        wait_done(100, 1);
        verify_reads("c5t", 5);
        verify_stream("c5t", 5);
        chk("c5t_stall_stable", stall_err - se0, 0);

        // stored count 250 is clamped
        load_cell(250);
        mark();
        start_pass(t0);
        wait_done(600, 0);
        chk("c250_pcount", int'(particle_count), PN - 1);
        chk("c250_err", int'(count_err), 1);
        verify_reads("c250", PN - 1);
        verify_stream("c250", PN - 1);

        // count = 219, back-to-back; count_err must clear on the accepted start
        load_cell(219);
        mark();
        start_pass(t0);
        chk("c219_err_cleared", int'(count_err), 0);
        wait_done(600, 0);
        chk("c219_pcount", int'(particle_count), 219);
        verify_reads("c219", 219);
        verify_stream("c219", 219);
        if (hs_cyc.size() >= hs0 + 219) chk("c219_b2b", hs_cyc[hs0 + 218] - hs_cyc[hs0], 218);

        // start pulsed mid-stream is ignored
        load_cell(5);
        mark();
        start_pass(t0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(60, 0);
        verify_reads("midstart", 5);
        verify_stream("midstart", 5);
        chk("midstart_one_done", done_cyc.size() - d0, 1);

        // reset dropped while word 2 is presented
        mark();
        start_pass(t0);
        found = 0;
        for (int s = 0; s < 40 && found == 0; s++) begin
            @(posedge clk); #1;
            if (bus.out_valid && bus.out_index == 8'd2) found = 1;
        end
        chk("rst_word2_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_index", int'(bus.out_index), 0);
        chk("arst_data_zero", int'(bus.out_data == '0), 1);
        chk("arst_rden", int'(bus.mem_rden), 0);
        chk("arst_pcount", int'(particle_count), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_no_done", done_cyc.size() - d0, 0);
        chk("arst_idle_valid", int'(bus.out_valid), 0);
        mark();
        start_pass(t0);
        wait_done(60, 0);
        verify_reads("fresh", 5);
        verify_stream("fresh", 5);

        chk("wren_zero", wren_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
